// File: rtl/regfile_sb.sv
// Purpose    : 2R/1W register file with per-register pending scoreboard and pending count.
// Latency    : reads are combinational; writes and issue marks are visible the cycle after the edge.
// Backpressure: none; ID-stage hazard logic stalls on busy_a/busy_b.
//
// Ports:
//   clk, clrn          rising-edge clock, synchronous active-low reset
//   rna/rnb -> qa/qb   asynchronous read ports; busy_a/busy_b report pending producers
//   we, wn, d          writeback port (clears the pending bit of wn)
//   iss_en, iss_wn     issue port (sets the pending bit of iss_wn)
//   pend_cnt           number of pending registers (register 0 never counts)
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module regfile_sb #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int RESET_IDENT = 0
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          we,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] d,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_wn,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   pend_cnt
);
    localparam int NREG = 2 ** AW;

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [AW:0]     cnt_q, cnt_d;

    logic wr_hit, iss_hit, cnt_inc, cnt_dec;

    // Register 0 is never written, so its entry stays at its reset value of 0.
    assign wr_hit  = we && (wn != '0);
    assign iss_hit = iss_en && (iss_wn != '0);

    function automatic logic [DW-1:0] rst_val(input int idx);
        if (RESET_IDENT != 0 && idx >= 1 && idx <= 8) begin
            return DW'(idx);
        end
        return '0;
    endfunction

    // Set wins over clear when issue and writeback hit the same register:
    // a younger producer is already in flight for it.
    always_comb begin
        pend_d = pend_q;
        if (wr_hit) begin
            pend_d[wn] = 1'b0;
        end
        if (iss_hit) begin
            pend_d[iss_wn] = 1'b1;
        end
    end

    // Count only real transitions of pend bits so the count tracks the set size
    // exactly and can never wrap.
    always_comb begin
        cnt_inc = iss_hit && !pend_q[iss_wn];
        cnt_dec = wr_hit && pend_q[wn] && !(iss_hit && (iss_wn == wn));
        cnt_d   = cnt_q + (AW + 1)'(cnt_inc) - (AW + 1)'(cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= rst_val(i);
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[wn] <= d;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

`ifdef REGFILE_BYPASS_EN
    // Write-through: the WB value and a cleared busy are seen in the same cycle,
    // even if a new issue to that register is also happening this cycle.
    always_comb begin
        qa     = (rna == '0) ? '0 : regs_q[rna];
        busy_a = (rna != '0) && pend_q[rna];
        if (wr_hit && (rna == wn)) begin
            qa     = d;
            busy_a = 1'b0;
        end
        qb     = (rnb == '0) ? '0 : regs_q[rnb];
        busy_b = (rnb != '0) && pend_q[rnb];
        if (wr_hit && (rnb == wn)) begin
            qb     = d;
            busy_b = 1'b0;
        end
    end
`else
    always_comb begin
        qa     = (rna == '0) ? '0 : regs_q[rna];
        busy_a = (rna != '0) && pend_q[rna];
        qb     = (rnb == '0) ? '0 : regs_q[rnb];
        busy_b = (rnb != '0) && pend_q[rnb];
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Purpose    : self-checking bench for regfile_sb (RESET_IDENT=1) against a register/scoreboard model.
// Latency    : inputs driven on the falling edge, outputs checked 1 time unit later.
// Backpressure: not applicable.
module tb_regfile_sb;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic          clk = 1'b0;
    logic          clrn;
    logic [AW-1:0] rna, rnb, wn, iss_wn;
    logic [DW-1:0] qa, qb, d;
    logic          we, iss_en, busy_a, busy_b;
    logic [AW:0]   pend_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mreg  [NREG];
    bit            mpend [NREG];

    always #5 clk = ~clk;

    regfile_sb #(.DW(DW), .AW(AW), .RESET_IDENT(1)) dut (
        .clk(clk), .clrn(clrn),
        .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .we(we), .wn(wn), .d(d),
        .iss_en(iss_en), .iss_wn(iss_wn),
        .busy_a(busy_a), .busy_b(busy_b), .pend_cnt(pend_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: registers are an array, the scoreboard is a set of pending indices.
    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wn != 0 && wn == a) return d;
`endif
        return mreg[a];
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && wn != 0 && wn == a) return 1'b0;
`endif
        return mpend[a];
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += mpend[i] ? 1 : 0;
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) begin
            mreg[i]  = (i >= 1 && i <= 8) ? DW'(i) : '0;
            mpend[i] = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".qa"},     qa,       m_read(rna));
        check({tag, ".qb"},     qb,       m_read(rnb));
        check({tag, ".busy_a"}, busy_a,   m_busy(rna));
        check({tag, ".busy_b"}, busy_b,   m_busy(rnb));
        check({tag, ".cnt"},    pend_cnt, 64'(m_cnt()));
    endtask

    // One rising edge: apply the model update with the inputs held across it.
    task automatic step();
        @(posedge clk);
        if (!clrn) begin
            m_reset();
        end else begin
            if (we && wn != 0) begin
                mreg[wn]  = d;
                mpend[wn] = 1'b0;
            end
            if (iss_en && iss_wn != 0) mpend[iss_wn] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        clrn = 1'b1; we = 1'b0; iss_en = 1'b0; wn = '0; iss_wn = '0; d = '0;
    endtask

    initial begin
        idle();
        rna = '0; rnb = '0;
        @(negedge clk);

        // Reset with identity values
        clrn = 1'b0;
        step();
        idle();
        rna = 5'd4; rnb = 5'd9;
        #1;
        check("rst.qa", qa, 64'h4);
        check("rst.qb", qb, 64'h0);
        check("rst.busy_a", busy_a, 64'h0);
        check("rst.busy_b", busy_b, 64'h0);
        check("rst.cnt", pend_cnt, 64'h0);

        // Zero register is hardwired
        we = 1'b1; wn = 5'd0; d = 32'hDEADBEEF;
        step();
        idle();
        iss_en = 1'b1; iss_wn = 5'd0;
        rna = 5'd0;
        step();
        idle();
        #1;
        check("zero.qa", qa, 64'h0);
        check("zero.busy", busy_a, 64'h0);
        check("zero.cnt", pend_cnt, 64'h0);

        // Write then read, including same-cycle read
        we = 1'b1; wn = 5'd7; d = 32'h12345678; rna = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wr.same_cycle", qa, 64'h12345678);
`else
        check("wr.same_cycle", qa, 64'h7);
`endif
        step();
        idle();
        #1;
        check("wr.next_cycle", qa, 64'h12345678);

        // Scoreboard
        iss_en = 1'b1; iss_wn = 5'd3;
        step();
        iss_wn = 5'd5;
        step();
        idle();
        rna = 5'd3; rnb = 5'd5;
        #1;
        check("sb.cnt2", pend_cnt, 64'd2);
        check("sb.busy3", busy_a, 64'h1);
        check("sb.busy5", busy_b, 64'h1);
        iss_en = 1'b1; iss_wn = 5'd3;
        step();
        idle();
        #1;
        check("sb.reissue_cnt", pend_cnt, 64'd2);
        we = 1'b1; wn = 5'd3; d = 32'h33;
        step();
        idle();
        #1;
        check("sb.wr3_busy", busy_a, 64'h0);
        check("sb.wr3_cnt", pend_cnt, 64'd1);
        we = 1'b1; wn = 5'd9; d = 32'h99;
        step();
        idle();
        #1;
        check("sb.wr9_cnt", pend_cnt, 64'd1);

        // Simultaneous issue+write, same register, already pending
        we = 1'b1; wn = 5'd5; d = 32'hA5; iss_en = 1'b1; iss_wn = 5'd5;
        step();
        idle();
        rna = 5'd5;
        #1;
        check("same5.qa", qa, 64'hA5);
        check("same5.busy", busy_a, 64'h1);
        check("same5.cnt", pend_cnt, 64'd1);
        // Same, register not pending
        we = 1'b1; wn = 5'd6; d = 32'hB6; iss_en = 1'b1; iss_wn = 5'd6;
        step();
        idle();
        rna = 5'd6;
        #1;
        check("same6.qa", qa, 64'hB6);
        check("same6.busy", busy_a, 64'h1);
        check("same6.cnt", pend_cnt, 64'd2);
        check_all("same6.model");

        // Reset mid-operation with three pending and a write in flight
        iss_en = 1'b1; iss_wn = 5'd10;
        step();
        idle();
        #1;
        check("mid.cnt3", pend_cnt, 64'd3);
        clrn = 1'b0; we = 1'b1; wn = 5'd7; d = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_wn = 5'd12;
        step();
        idle();
        rna = 5'd7; rnb = 5'd5;
        #1;
        check("mid.q7", qa, 64'h7);
        check("mid.busy5", busy_b, 64'h0);
        check("mid.cnt0", pend_cnt, 64'd0);
        we = 1'b1; wn = 5'd5; d = 32'h55;
        step();
        idle();
        #1;
        check("mid.late_wb_q", qb, 64'h55);
        check("mid.late_wb_cnt", pend_cnt, 64'd0);

        // Randomized traffic against the model (small address range raises collisions)
        for (int n = 0; n < 400; n++) begin
            clrn   = ($urandom_range(0, 60) != 0);
            we     = $urandom_range(0, 1) == 1;
            wn     = AW'($urandom_range(0, (n < 200) ? 7 : 31));
            d      = $urandom;
            iss_en = $urandom_range(0, 2) != 0;
            iss_wn = AW'($urandom_range(0, (n < 200) ? 7 : 31));
            rna    = ($urandom_range(0, 1) == 1) ? wn : AW'($urandom_range(0, 31));
            rnb    = ($urandom_range(0, 1) == 1) ? iss_wn : AW'($urandom_range(0, 31));
            check_all("rand");
            step();
        end
        idle();
        check_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipelined CPU's register file: 2 asynchronous read ports, 1 synchronous write port.
- Adds a per-register pending scoreboard (set at issue, cleared at writeback) and a pending-register counter.
- Lets ID-stage hazard logic stall on in-flight producers.
- Sits between ID (reads, issue) and WB (write).

Parameters:
- DW, 32, data width in bits.
- AW, 5, register address width; depth NREG = 2**AW, register 0 hardwired to zero.
- RESET_IDENT, 0, 0: all registers reset to 0; 1: register i resets to i for i = 1..8, all others to 0.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  synchronous active-low reset.
- rna  in  AW  read address, port A.
- rnb  in  AW  read address, port B.
- qa  out  DW  read data, port A.
- qb  out  DW  read data, port B.
- we  in  1  write enable (WB).
- wn  in  AW  write address.
- d  in  DW  write data.
- iss_en  in  1  issue strobe: mark destination pending.
- iss_wn  in  AW  issued destination register.
- busy_a  out  1  register rna is pending.
- busy_b  out  1  register rnb is pending.
- pend_cnt  out  AW+1  number of pending registers, 0..NREG-1.

Behaviour:
- Single clock clk; reset clrn is synchronous and active-low (sampled on the rising clk edge, 0 = reset).
- Reset: registers take their RESET_IDENT values; all pending bits clear; pend_cnt = 0.
  - Reset overrides we and iss_en in the same cycle.
  - Reset mid-operation discards all pending state; later writebacks to those registers still write the data but do not decrement pend_cnt.
- Read:
  - Combinational.
  - Address 0 returns 0 with busy = 0.
  - Otherwise returns the stored value and the pending bit, subject to the Optional Feature bypass.
- Write:
  - On a rising edge with clrn = 1, we = 1 and wn != 0, register[wn] <= d.
  - wn = 0 writes are ignored.
  - The write also clears pend[wn].
- Issue:
  - On a rising edge with iss_en = 1 and iss_wn != 0, pend[iss_wn] <= 1.
  - iss_wn = 0 is ignored.
- Simultaneous issue and write, same register: set wins (a new producer is in flight), pend stays 1; the data write still occurs.
- Simultaneous issue and write, different registers: both take effect.
- pend_cnt update each cycle: next = cnt + (set of a non-pending register) − (clear of a pending register).
  - Issue to an already-pending register does not increment.
  - Write to a non-pending register does not decrement.
  - Same-register set+clear leaves the count unchanged when pend = 1 and adds 1 when pend = 0.
  - The count never wraps: its max is NREG-1 because register 0 is excluded.
- Latency:
  - Write is visible on qa/qb the cycle after the edge (without bypass).
  - A pending bit is visible on busy the cycle after the issue edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if we = 1, wn != 0 and rna == wn, then qa = d and busy_a = 0 in the same cycle.
  - Port B behaves the same with rnb.
  - If iss_en targets the same register in that cycle, busy still reads 0 until the edge.
- Undefined:
  - Reads return the stored value; the pipeline must tolerate one cycle of WB-to-ID latency.
  - busy reflects the registered pend bit only.

Test Plan:
- Reset, RESET_IDENT=1: hold clrn=0 for 1 edge, read rna=4, rnb=9 -> qa=4, qb=0, busy_a=busy_b=0, pend_cnt=0.
- Zero register: we=1, wn=0, d=32'hDEADBEEF, then read rna=0 -> qa=0. Issue iss_wn=0 -> pend_cnt stays 0.
- Write then read: write wn=7, d=32'h12345678. Next cycle rna=7 -> qa=32'h12345678.
  - With REGFILE_BYPASS_EN: the same-cycle read returns 32'h12345678.
  - Without it: the same-cycle read returns the old value.
- Scoreboard: issue r3 and r5 on consecutive cycles -> pend_cnt=2, busy_a(rna=3)=1.
  - Re-issue r3 -> cnt stays 2.
  - Write r3 -> busy_a=0 next cycle, cnt=1.
  - Write r9 (not pending) -> cnt stays 1.
- Simultaneous same register: r5 pending, issue r5 and write r5 with d=32'hA5 in the same cycle -> pend[5]=1, register[5]=32'hA5, cnt unchanged.
  - Repeat with r6 not pending -> pend[6]=1, cnt+1.
- Reset mid-operation: three registers pending, assert clrn=0 for one edge while we=1 -> all busy=0, pend_cnt=0, written register holds its reset value.
